// File: rtl/spi_ram_ctrl.sv
// SPI master sequencer: turns one parallel read/write request into the wrapper's
// two-frame serial protocol (address frame, gap, data frame, optional MISO capture).
module spi_ram_ctrl #(
    parameter int ADDER_SIZE = 8,
    parameter int GAP        = 2,
    parameter int RD_GAP     = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_rw,
    input  logic [ADDER_SIZE-1:0] req_addr,
    input  logic [ADDER_SIZE-1:0] req_wdata,
    output logic                  rsp_valid,
    output logic [ADDER_SIZE-1:0] rsp_rdata,
    output logic                  SS_n,
    output logic                  MOSI,
    input  logic                  MISO
);

    localparam int FW = ADDER_SIZE + 4;
    localparam int CW = 4;

    localparam logic [CW-1:0] FRAME_LD = CW'(FW - 1);
    localparam logic [CW-1:0] CAPT_LD  = CW'(ADDER_SIZE - 1);
    localparam logic [CW-1:0] GAP_LD   = CW'(GAP - 1);
    localparam logic [CW-1:0] TURN_LD  = (RD_GAP > 0) ? CW'(RD_GAP - 1) : CW'(0);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FRAME1,
        S_GAP,
        S_FRAME2,
        S_TURN,
        S_CAPT,
        S_RESP
    } state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         bit_cnt_q, bit_cnt_d;
    logic [CW-1:0]         gap_cnt_q, gap_cnt_d;
    logic [FW-1:0]         tx_sh_q, tx_sh_d;
    logic [ADDER_SIZE-1:0] rx_sh_q, rx_sh_d;
    logic                  rw_q, rw_d;
    logic [ADDER_SIZE-1:0] addr_q, addr_d;
    logic [ADDER_SIZE-1:0] wdata_q, wdata_d;
    logic                  ss_n_q, ss_n_d;
    logic                  mosi_q, mosi_d;
    logic                  req_ready_q, req_ready_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [ADDER_SIZE-1:0] rsp_rdata_q, rsp_rdata_d;

    // Frame layout: filler, r/w select, then the 10-bit slave din = {cmd, byte}.
    function automatic logic [FW-1:0] frame_vec(input logic [1:0] cmd,
                                                input logic [ADDER_SIZE-1:0] payload);
        return {1'b0, cmd[1], cmd, payload};
    endfunction

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        gap_cnt_d   = gap_cnt_q;
        tx_sh_d     = tx_sh_q;
        rx_sh_d     = rx_sh_q;
        rw_d        = rw_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rsp_rdata_d = rsp_rdata_q;

        unique case (state_q)
            S_IDLE: begin
                if (req_valid && req_ready_q) begin
                    rw_d      = req_rw;
                    addr_d    = req_addr;
                    wdata_d   = req_wdata;
                    state_d   = S_FRAME1;
                    bit_cnt_d = FRAME_LD;
                    tx_sh_d   = frame_vec({req_rw, 1'b0}, req_addr);
                end
            end
            S_FRAME1: begin
                if (bit_cnt_q == '0) begin
                    state_d   = S_GAP;
                    gap_cnt_d = GAP_LD;
                end else begin
                    bit_cnt_d = bit_cnt_q - CNT_ONE;
                    tx_sh_d   = tx_sh_q << 1;
                end
            end
            S_GAP: begin
                if (gap_cnt_q == '0) begin
                    state_d   = S_FRAME2;
                    bit_cnt_d = FRAME_LD;
                    tx_sh_d   = frame_vec({rw_q, 1'b1}, rw_q ? '0 : wdata_q);
                end else begin
                    gap_cnt_d = gap_cnt_q - CNT_ONE;
                end
            end
            S_FRAME2: begin
                if (bit_cnt_q == '0) begin
                    if (!rw_q) begin
                        state_d = S_RESP;
                    end else if (RD_GAP == 0) begin
                        state_d   = S_CAPT;
                        bit_cnt_d = CAPT_LD;
                    end else begin
                        state_d   = S_TURN;
                        gap_cnt_d = TURN_LD;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q - CNT_ONE;
                    tx_sh_d   = tx_sh_q << 1;
                end
            end
            S_TURN: begin
                if (gap_cnt_q == '0) begin
                    state_d   = S_CAPT;
                    bit_cnt_d = CAPT_LD;
                end else begin
                    gap_cnt_d = gap_cnt_q - CNT_ONE;
                end
            end
            S_CAPT: begin
                rx_sh_d = {rx_sh_q[ADDER_SIZE-2:0], MISO};
                if (bit_cnt_q == '0) begin
                    state_d     = S_RESP;
                    rsp_rdata_d = rx_sh_d;
                end else begin
                    bit_cnt_d = bit_cnt_q - CNT_ONE;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Outputs are registered from the next state so they line up with it.
        ss_n_d      = !(state_d inside {S_FRAME1, S_FRAME2, S_TURN, S_CAPT});
        mosi_d      = (state_d == S_FRAME1 || state_d == S_FRAME2) ? tx_sh_d[FW-1] : 1'b0;
        req_ready_d = (state_d == S_IDLE);
        rsp_valid_d = (state_d == S_RESP);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            bit_cnt_q   <= '0;
            gap_cnt_q   <= '0;
            tx_sh_q     <= '0;
            rx_sh_q     <= '0;
            rw_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            ss_n_q      <= 1'b1;
            mosi_q      <= 1'b0;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
            tx_sh_q     <= tx_sh_d;
            rx_sh_q     <= rx_sh_d;
            rw_q        <= rw_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            ss_n_q      <= ss_n_d;
            mosi_q      <= mosi_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign SS_n      = ss_n_q;
    assign MOSI      = mosi_q;

endmodule

// File: tb/tb_spi_ram_ctrl.sv
// Bench for spi_ram_ctrl: a wrapper-side slave/RAM model plus a cycle-level
// expectation built from the frame timing rules and a reference memory.
module tb_spi_ram_ctrl;

    localparam int AW     = 8;
    localparam int GAP    = 2;
    localparam int RD_GAP = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_rw = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [AW-1:0] req_wdata = '0;
    logic          rsp_valid;
    logic [AW-1:0] rsp_rdata;
    logic          SS_n;
    logic          MOSI;
    logic          MISO = 1'b0;

    int checks = 0;
    int errors = 0;

    logic [7:0] ref_mem [256] = '{default: 8'h00};
    logic [7:0] cur_rdata = 8'h00;

    spi_ram_ctrl #(.ADDER_SIZE(AW), .GAP(GAP), .RD_GAP(RD_GAP)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_rw    (req_rw),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .SS_n      (SS_n),
        .MOSI      (MOSI),
        .MISO      (MISO)
    );

    always #5 clk = ~clk;

    // Wrapper model: decodes 12-bit frames, owns its own RAM, answers reads on MISO.
    logic [11:0] sl_sh = '0;
    int          sl_bits = 0;
    int          sl_tail = 0;
    logic [7:0]  sl_waddr = '0;
    logic [7:0]  sl_raddr = '0;
    logic [7:0]  sl_out = '0;
    logic [7:0]  sl_mem [256] = '{default: 8'h00};

    always @(negedge clk) begin
        if (SS_n !== 1'b0) begin
            sl_bits = 0;
            sl_tail = 0;
            MISO    = 1'b0;
        end else if (sl_bits < 12) begin
            sl_sh = {sl_sh[10:0], MOSI};
            sl_bits++;
            if (sl_bits == 12) begin
                case (sl_sh[9:8])
                    2'b00: sl_waddr = sl_sh[7:0];
                    2'b01: sl_mem[sl_waddr] = sl_sh[7:0];
                    2'b10: sl_raddr = sl_sh[7:0];
                    default: begin
                        sl_out  = sl_mem[sl_raddr];
                        sl_tail = 1;
                    end
                endcase
            end
        end else if (sl_tail > 0) begin
            if (sl_tail > RD_GAP && sl_tail <= RD_GAP + 8)
                MISO = sl_out[7 - (sl_tail - RD_GAP - 1)];
            else
                MISO = 1'b0;
            sl_tail++;
        end
    end

    int rsp_cnt = 0;
    int ss_run = 0;
    int min_run = 1000;
    bit seen_low = 1'b0;

    always @(negedge clk) begin
        if (rsp_valid === 1'b1) rsp_cnt++;
        if (rst_n !== 1'b1) begin
            ss_run   = 0;
            seen_low = 1'b0;
        end else if (SS_n === 1'b1) begin
            ss_run++;
        end else begin
            if (seen_low && ss_run > 0 && ss_run < min_run) min_run = ss_run;
            ss_run   = 0;
            seen_low = 1'b1;
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // mode 0: drop valid, zero the request fields in frame 1
    // mode 1: drop valid, scramble the request fields every cycle
    // mode 2: keep valid high and present the next request (nrw/naddr/nwd)
    task automatic do_txn(input logic rw, input logic [7:0] addr, input logic [7:0] wdata,
                          input int mode, input int abort_j,
                          input logic nrw, input logic [7:0] naddr, input logic [7:0] nwd);
        int         n;
        int         waited;
        logic [11:0] f1;
        logic [11:0] f2;
        logic [7:0] exp_rd;
        logic       ess;
        logic       emo;
        logic       erv;
        logic [7:0] erd;
        req_rw    = rw;
        req_addr  = addr;
        req_wdata = wdata;
        req_valid = 1'b1;
        waited    = 0;
        while (req_ready !== 1'b1 && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (req_ready !== 1'b1) begin
            check_val("accept_timeout", {31'd0, req_ready}, 32'd1);
            req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        if (mode == 2) begin
            req_rw    = nrw;
            req_addr  = naddr;
            req_wdata = nwd;
        end else begin
            req_valid = 1'b0;
        end
        f1     = {1'b0, rw, rw, 1'b0, addr};
        f2     = {1'b0, rw, rw, 1'b1, rw ? 8'h00 : wdata};
        exp_rd = ref_mem[addr];
        n      = rw ? 33 + GAP + RD_GAP : 25 + GAP;
        for (int j = 1; j <= n; j++) begin
            @(negedge clk);
            ess = 1'b1;
            emo = 1'b0;
            erv = 1'b0;
            erd = cur_rdata;
            if (j <= 12) begin
                ess = 1'b0;
                emo = f1[12 - j];
            end else if (j >= 13 + GAP && j <= 24 + GAP) begin
                ess = 1'b0;
                emo = f2[24 + GAP - j];
            end else if (j > 24 + GAP && j < n) begin
                ess = 1'b0;
            end
            if (j == n) begin
                erv = 1'b1;
                if (rw) begin
                    erd       = exp_rd;
                    cur_rdata = exp_rd;
                end
            end
            check_val($sformatf("%s_a%02h_c%0d", rw ? "rd" : "wr", addr, j),
                      {20'd0, SS_n, MOSI, rsp_valid, req_ready, rsp_rdata},
                      {20'd0, ess, emo, erv, 1'b0, erd});
            if (mode == 0 && j == 5) begin
                req_addr  = 8'h00;
                req_wdata = 8'h00;
            end else if (mode == 1) begin
                req_rw    = 1'($urandom);
                req_addr  = 8'($urandom);
                req_wdata = 8'($urandom);
            end
            if (j == abort_j) begin
                rst_n = 1'b0;
                @(negedge clk);
                check_val("abort_outs", {20'd0, SS_n, MOSI, rsp_valid, req_ready, rsp_rdata},
                          {20'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00});
                cur_rdata = 8'h00;
                rst_n     = 1'b1;
                @(negedge clk);
                check_val("abort_rdy", {31'd0, req_ready}, 32'd1);
                check_val("abort_no_rsp", {31'd0, rsp_valid}, 32'd0);
                $display("txn abort wr addr=%h wdata=%h at cycle %0d", addr, wdata, j);
                return;
            end
        end
        if (!rw) ref_mem[addr] = wdata;
        $display("txn %s addr=%h wdata=%h rdata=%h rsp_cycle=k+%0d",
                 rw ? "rd" : "wr", addr, wdata, rsp_rdata, n);
        if (mode != 2) begin
            @(negedge clk);
            check_val("rdy_after_resp", {31'd0, req_ready}, 32'd1);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int b0;
        logic       rrw;
        logic [7:0] raddr;
        logic [7:0] rwd;

        // Reset held for 15 cycles
        for (int i = 1; i <= 15; i++) begin
            @(negedge clk);
            check_val($sformatf("rst_c%0d", i),
                      {20'd0, SS_n, MOSI, rsp_valid, req_ready, rsp_rdata},
                      {20'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00});
        end
        rst_n = 1'b1;
        @(negedge clk);
        check_val("rdy_after_rst", {31'd0, req_ready}, 32'd1);

        // Directed write, read, write
        do_txn(1'b0, 8'hFF, 8'h55, 0, 0, 1'b0, 8'h00, 8'h00);
        do_txn(1'b1, 8'hFF, 8'h00, 0, 0, 1'b0, 8'h00, 8'h00);
        check_val("rd_ff", {24'd0, rsp_rdata}, 32'h55);
        do_txn(1'b0, 8'h01, 8'h99, 0, 0, 1'b0, 8'h00, 8'h00);
        check_val("rdata_hold", {24'd0, rsp_rdata}, 32'h55);

        // Back-to-back with req_valid held high
        #1;
        b0 = rsp_cnt;
        do_txn(1'b1, 8'hFF, 8'h00, 2, 0, 1'b0, 8'h33, 8'hC3);
        do_txn(1'b0, 8'h33, 8'hC3, 0, 0, 1'b0, 8'h00, 8'h00);
        #1;
        check_val("b2b_rsp_cnt", rsp_cnt - b0, 32'd2);

        // Input stability: fields zeroed mid-frame 1
        do_txn(1'b0, 8'h10, 8'hA5, 0, 0, 1'b0, 8'h00, 8'h00);
        do_txn(1'b1, 8'h10, 8'h00, 0, 0, 1'b0, 8'h00, 8'h00);
        check_val("rd_10", {24'd0, rsp_rdata}, 32'hA5);

        // Reset during frame 2 bit 5 of a write
        #1;
        b0 = rsp_cnt;
        do_txn(1'b0, 8'h20, 8'h77, 0, 13 + GAP + 5, 1'b0, 8'h00, 8'h00);
        #1;
        check_val("abort_rsp_cnt", rsp_cnt - b0, 32'd0);
        do_txn(1'b0, 8'h20, 8'h3C, 0, 0, 1'b0, 8'h00, 8'h00);
        do_txn(1'b1, 8'h20, 8'h00, 0, 0, 1'b0, 8'h00, 8'h00);
        check_val("rd_20", {24'd0, rsp_rdata}, 32'h3C);

        // Randomized traffic over a small address window
        for (int i = 0; i < 24; i++) begin
            rrw   = 1'($urandom_range(0, 1));
            raddr = 8'($urandom_range(0, 7));
            rwd   = 8'($urandom);
            do_txn(rrw, raddr, rwd, 1, 0, 1'b0, 8'h00, 8'h00);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        check_val("ss_high_min", min_run, 32'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
